// File: rtl/dynamic_int_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : dynamic_int_alu_pipe
// Brief   : Elastic ADD/SUB/MUL/PASS_A ALU pipeline with tag sideband,
//           bubble-collapsing stage advance and an in-flight occupancy count.
// Rev     : 1.0
// ============================================================================
module dynamic_int_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             operand_a,
    input  logic [WIDTH-1:0]             operand_b,
    input  logic [1:0]                   operation,
    input  logic [TAG_W-1:0]             tag_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [WIDTH-1:0]             result,
    output logic                         overflow,
    output logic [TAG_W-1:0]             tag_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int         OCC_W  = $clog2(STAGES + 1);
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    // The low 2*WIDTH bits of the sign-extended product equal the signed product.
    always_comb begin
        sum     = operand_a + operand_b;
        diff    = operand_a - operand_b;
        a_ext   = {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
        b_ext   = {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
        prod    = a_ext * b_ext;
        alu_res = operand_a;
        alu_ovf = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                alu_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            end
            default: ;
        endcase
    end

    logic               valid_q [STAGES];
    logic               valid_d [STAGES];
    logic [WIDTH-1:0]   res_q   [STAGES];
    logic [WIDTH-1:0]   res_d   [STAGES];
    logic               ovf_q   [STAGES];
    logic               ovf_d   [STAGES];
    logic [TAG_W-1:0]   tag_q   [STAGES];
    logic [TAG_W-1:0]   tag_d   [STAGES];
    logic               adv     [STAGES];
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               in_xfer;
    logic               out_xfer;

    // Enable chain: a stage moves on when the next one is empty or leaving too.
    always_comb begin
        logic go;
        go             = valid_q[STAGES-1] && ready_in;
        adv[STAGES-1]  = go;
        for (int k = STAGES - 2; k >= 0; k--) begin
            go     = valid_q[k] && (!valid_q[k+1] || go);
            adv[k] = go;
        end
    end

    assign ready_out = !valid_q[0] || adv[0];
    assign in_xfer   = valid_in && ready_out;
    assign out_xfer  = adv[STAGES-1];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k] && !adv[k];
            res_d[k]   = res_q[k];
            ovf_d[k]   = ovf_q[k];
            tag_d[k]   = tag_q[k];
        end
        if (in_xfer) begin
            valid_d[0] = 1'b1;
            res_d[0]   = alu_res;
            ovf_d[0]   = alu_ovf;
            tag_d[0]   = tag_in;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                valid_d[k] = 1'b1;
                res_d[k]   = res_q[k-1];
                ovf_d[k]   = ovf_q[k-1];
                tag_d[k]   = tag_q[k-1];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                ovf_q[k]   <= 1'b0;
                tag_q[k]   <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                res_q[k]   <= res_d[k];
                ovf_q[k]   <= ovf_d[k];
                tag_q[k]   <= tag_d[k];
            end
            occ_q <= occ_d;
        end
    end

    assign valid_out = valid_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign overflow  = ovf_q[STAGES-1];
    assign tag_out   = tag_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_dynamic_int_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_dynamic_int_alu_pipe
// Brief   : Directed and randomized self-checking bench with a queue-based
//           arithmetic reference model; extra instances at STAGES 1, 4 and 8.
// Rev     : 1.0
// ============================================================================
module tb_dynamic_int_alu_pipe;

    localparam int WIDTH  = 32;
    localparam int TAG_W  = 4;
    localparam int STAGES = 3;
    localparam int N_RAND = 1000;
    localparam int CFG_S [3] = '{1, 4, 8};
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] operand_a, operand_b, result;
    logic [1:0]       operation;
    logic [TAG_W-1:0] tag_in, tag_out;
    logic             valid_in, ready_out, overflow, valid_out, ready_in;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dynamic_int_alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
        .operation(operation), .tag_in(tag_in), .valid_in(valid_in), .ready_out(ready_out),
        .result(result), .overflow(overflow), .tag_out(tag_out), .valid_out(valid_out),
        .ready_in(ready_in), .occupancy(occupancy)
    );

    // Reference arithmetic done in 64-bit signed integers, then range-checked.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op, input logic [TAG_W-1:0] t);
        exp_t   e;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = sa;
        endcase
        e.res = r[WIDTH-1:0];
        e.ovf = (op != 2'd3) && ((r > MAXV) || (r < MINV));
        e.tag = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            3:       return 32'($urandom_range(0, 70000));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- reference scoreboard for the STAGES=3 instance --------
    exp_t             q[$];
    bit               stall_q = 1'b0;
    logic [WIDTH-1:0] held_res;
    logic             held_ovf;
    logic [TAG_W-1:0] held_tag;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            stall_q = 1'b0;
        end else begin
            check("occupancy", occupancy, q.size());
            check("ready_out", ready_out, (q.size() < STAGES) || ready_in);
            if (stall_q) begin
                check("hold_valid", valid_out, 1);
                check("hold_result", result, held_res);
                check("hold_overflow", overflow, held_ovf);
                check("hold_tag", tag_out, held_tag);
            end
            if (valid_out) begin
                if (q.size() == 0) begin
                    check("out_when_empty", valid_out, 0);
                end else begin
                    check("result", result, q[0].res);
                    check("overflow", overflow, q[0].ovf);
                    check("tag_out", tag_out, q[0].tag);
                end
            end
            stall_q  = valid_out && !ready_in;
            held_res = result;
            held_ovf = overflow;
            held_tag = tag_out;
            if (valid_out && ready_in && q.size() > 0) void'(q.pop_front());
            if (valid_in && ready_out) q.push_back(model(operand_a, operand_b, operation, tag_in));
        end
    end

    // Called right after a rising edge; returns right after a rising edge.
    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] t,
                         input int max_cycles, output bit ok);
        operand_a = a; operand_b = b; operation = op; tag_in = t; valid_in = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < max_cycles && !ok; c++) begin
            @(negedge clk);
            if (ready_out) ok = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic single(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] er, input logic eo);
        bit ok;
        ready_in = 1'b1;
        offer(a, b, op, t, 4, ok);
        check({nm, "_accept"}, ok, 1);
        for (int c = 1; c <= STAGES; c++) begin
            @(negedge clk);
            check({nm, "_latency_valid"}, valid_out, (c == STAGES));
            if (c == STAGES) begin
                check({nm, "_result"}, result, er);
                check({nm, "_overflow"}, overflow, eo);
                check({nm, "_tag"}, tag_out, t);
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- STAGES 1/4/8 instances on a shared transaction list ---
    logic [WIDTH-1:0] ta_a   [N_RAND];
    logic [WIDTH-1:0] ta_b   [N_RAND];
    logic [1:0]       ta_op  [N_RAND];
    logic [TAG_W-1:0] ta_tag [N_RAND];
    bit               cfg_go = 1'b0;
    bit               cfg_done [3];

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int S  = CFG_S[g];
        localparam int OW = $clog2(S + 1);
        logic [WIDTH-1:0] a, b, res;
        logic [1:0]       op;
        logic [TAG_W-1:0] tin, tout;
        logic             vin, rdy_o, ovf, vout, rdy_i;
        logic [OW-1:0]    occ;
        int               acc = 0;
        int               outn = 0;

        dynamic_int_alu_pipe #(.WIDTH(WIDTH), .STAGES(S), .TAG_W(TAG_W)) u_dut (
            .clk(clk), .reset(reset), .operand_a(a), .operand_b(b), .operation(op),
            .tag_in(tin), .valid_in(vin), .ready_out(rdy_o), .result(res), .overflow(ovf),
            .tag_out(tout), .valid_out(vout), .ready_in(rdy_i), .occupancy(occ)
        );

        initial begin
            vin = 1'b0; a = '0; b = '0; op = '0; tin = '0; rdy_i = 1'b0;
            cfg_done[g] = 1'b0;
            wait (cfg_go);
            while (outn < N_RAND) begin
                @(posedge clk); #1;
                vin   = (acc < N_RAND) && ($urandom_range(0, 3) != 0);
                rdy_i = ($urandom_range(0, 3) != 0);
                if (vin) begin
                    a = ta_a[acc]; b = ta_b[acc]; op = ta_op[acc]; tin = ta_tag[acc];
                end else begin
                    a = $urandom; b = $urandom; op = 2'($urandom); tin = 4'($urandom);
                end
            end
            vin = 1'b0;
            cfg_done[g] = 1'b1;
        end

        always @(negedge clk) begin
            if (cfg_go && reset) begin
                exp_t e;
                check("cfg_occupancy", occ, acc - outn);
                check("cfg_ready_out", rdy_o, ((acc - outn) < S) || rdy_i);
                if (vout) begin
                    if (outn >= acc) begin
                        check("cfg_out_when_empty", vout, 0);
                    end else begin
                        e = model(ta_a[outn], ta_b[outn], ta_op[outn], ta_tag[outn]);
                        check("cfg_result", res, e.res);
                        check("cfg_overflow", ovf, e.ovf);
                        check("cfg_tag", tout, e.tag);
                    end
                    if (rdy_i) outn++;
                end
                if (vin && rdy_o) acc++;
            end
        end
    end

    // ---------------- main sequence ----------------------------------------
    initial begin
        bit               ok;
        int               first, last, cnt, occ_bad, stale;
        logic [WIDTH-1:0] h_res;
        logic [TAG_W-1:0] h_tag;
        logic [WIDTH-1:0] x3a, x3b;

        valid_in = 1'b0; ready_in = 1'b0; operand_a = '0; operand_b = '0;
        operation = '0; tag_in = '0;
        for (int i = 0; i < N_RAND; i++) begin
            ta_a[i] = rand_operand(); ta_b[i] = rand_operand();
            ta_op[i] = 2'($urandom); ta_tag[i] = 4'($urandom);
        end

        check("model_add_ovf", model(32'h7FFF_FFFF, 32'h1, 2'd0, 4'h0), {32'h8000_0000, 1'b1, 4'h0});
        check("model_mul_neg", model(32'hFFFF_FFFE, 32'h3, 2'd2, 4'h9), {32'hFFFF_FFFA, 1'b0, 4'h9});
        check("model_sub_min", model(32'h8000_0000, 32'h1, 2'd1, 4'h0), {32'h7FFF_FFFF, 1'b1, 4'h0});

        repeat (3) @(posedge clk); #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tag_out", tag_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_out", ready_out, 1);

        single("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'd0, 4'h3, 32'h8000_0000, 1'b1);
        single("mul_ovf", 32'h0001_0000, 32'h0001_0000, 2'd2, 4'h1, 32'h0000_0000, 1'b1);
        single("mul_neg", 32'hFFFF_FFFE, 32'h0000_0003, 2'd2, 4'h2, 32'hFFFF_FFFA, 1'b0);
        single("sub_tag", 32'h0000_0003, 32'h0000_0001, 2'd1, 4'h5, 32'h0000_0002, 1'b0);
        single("pass_a",  32'h8000_0000, 32'h7FFF_FFFF, 2'd3, 4'hE, 32'h8000_0000, 1'b0);
        single("sub_ovf", 32'h8000_0000, 32'h0000_0001, 2'd1, 4'h7, 32'h7FFF_FFFF, 1'b1);

        // 20 back-to-back transactions with no backpressure
        ready_in = 1'b1;
        first = -1; last = -1; cnt = 0; occ_bad = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    operand_a = rand_operand(); operand_b = rand_operand();
                    operation = 2'($urandom); tag_in = 4'(i); valid_in = 1'b1;
                    @(posedge clk); #1;
                end
                valid_in = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (valid_out) begin
                        if (first < 0) first = c;
                        last = c;
                        cnt++;
                    end
                    if (c >= 3 && c <= 20 && occupancy != 2'd3) occ_bad++;
                end
            end
        join
        check("stream_count", cnt, 20);
        check("stream_first_cycle", first, 3);
        check("stream_contiguous", last - first, 19);
        check("stream_occ_steady_bad", occ_bad, 0);
        @(posedge clk); #1;

        // Backpressure: five offered, three fit
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(rand_operand(), rand_operand(), 2'($urandom), 4'(i + 8), 4, ok);
            check("bp_accept", ok, 1);
        end
        @(negedge clk);
        check("bp_full_ready_out", ready_out, 0);
        check("bp_full_occupancy", occupancy, 3);
        check("bp_full_valid_out", valid_out, 1);
        h_res = result; h_tag = tag_out;
        @(posedge clk); #1;
        x3a = rand_operand(); x3b = rand_operand();
        offer(x3a, x3b, 2'd0, 4'hB, 6, ok);
        check("bp_blocked", ok, 0);
        @(negedge clk);
        check("bp_head_result_stable", result, h_res);
        check("bp_head_tag_stable", tag_out, h_tag);
        @(posedge clk); #1;
        ready_in = 1'b1;
        #1;
        check("bp_full_pass_ready", ready_out, 1);
        offer(x3a, x3b, 2'd0, 4'hB, 4, ok);
        check("bp_accept_4th", ok, 1);
        offer(rand_operand(), rand_operand(), 2'd2, 4'hC, 4, ok);
        check("bp_accept_5th", ok, 1);
        repeat (8) @(posedge clk); #1;
        check("bp_drained_occ", occupancy, 0);
        check("bp_drained_model", q.size(), 0);

        // Randomized handshakes; held inputs change freely when not accepted
        for (int i = 0; i < 600; i++) begin
            valid_in  = ($urandom_range(0, 2) != 0);
            ready_in  = ($urandom_range(0, 2) != 0);
            operand_a = rand_operand(); operand_b = rand_operand();
            operation = 2'($urandom); tag_in = 4'($urandom);
            @(posedge clk); #1;
        end
        valid_in = 1'b0; ready_in = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("rand_drained_model", q.size(), 0);

        // Reset with two in flight
        ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(rand_operand(), rand_operand(), 2'($urandom), 4'hF, 4, ok);
            check("rst_pre_accept", ok, 1);
        end
        repeat (3) @(posedge clk); #1;
        check("rst_pre_occ", occupancy, 2);
        check("rst_pre_valid", valid_out, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_valid_out", valid_out, 0);
        check("rst_async_occupancy", occupancy, 0);
        check("rst_async_result", result, 0);
        check("rst_async_tag", tag_out, 0);
        @(posedge clk); #1;
        reset = 1'b1; ready_in = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        check("rst_no_stale_output", stale, 0);
        @(posedge clk); #1;

        // Cross-configuration run
        cfg_go = 1'b1;
        for (int c = 0; c < 20000 && !(cfg_done[0] && cfg_done[1] && cfg_done[2]); c++)
            @(posedge clk);
        check("cfg_complete", {cfg_done[0], cfg_done[1], cfg_done[2]}, 3'b111);
        check("cfg1_delivered", g_cfg[0].outn, N_RAND);
        check("cfg4_delivered", g_cfg[1].outn, N_RAND);
        check("cfg8_delivered", g_cfg[2].outn, N_RAND);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dynamic_int_alu_pipe.md
DYNAMIC_INT_ALU_PIPE -- requirements
Module: dynamic_int_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 8..64.
REQ-002 Parameter STAGES, default 3: number of elastic pipeline stages, legal range 1..8.
REQ-003 Parameter TAG_W, default 4: width of the sideband tag that travels with each transaction.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 operand_a  in  WIDTH  first operand, two's complement.
REQ-007 operand_b  in  WIDTH  second operand, two's complement.
REQ-008 operation  in  2  operation select: 0 ADD, 1 SUB (a-b), 2 MUL, 3 PASS_A.
REQ-009 tag_in  in  TAG_W  user tag, returned unchanged with the result.
REQ-010 valid_in  in  1  input transaction valid.
REQ-011 ready_out  out  1  block can accept an input this cycle.
REQ-012 result  out  WIDTH  result of the head transaction.
REQ-013 overflow  out  1  signed overflow flag of the head transaction.
REQ-014 tag_out  out  TAG_W  tag of the head transaction.
REQ-015 valid_out  out  1  head transaction valid.
REQ-016 ready_in  in  1  downstream accepts the head transaction.
REQ-017 occupancy  out  $clog2(STAGES+1)  number of transactions in flight, 0..STAGES.

Function
REQ-018 An input transfer occurs at a rising edge where valid_in && ready_out; an output transfer occurs at a rising edge where valid_out && ready_in.
REQ-019 The arithmetic result SHALL be computed combinationally from the accepted inputs and written into stage 0 at the input transfer edge, together with overflow and tag.
REQ-020 ADD/SUB: result = low WIDTH bits of the sum or difference; overflow = 1 iff the signed result is not representable in WIDTH bits.
REQ-021 MUL: result = low WIDTH bits of the signed product; overflow = 1 iff the full 2*WIDTH-bit signed product differs from the sign extension of result.
REQ-022 PASS_A: result = operand_a; overflow = 0.
REQ-023 Stages s[0]..s[STAGES-1] each hold a valid bit and a payload; result, overflow, tag_out and valid_out SHALL be driven directly from s[STAGES-1].
REQ-024 Stage k, for k < STAGES-1, SHALL advance into stage k+1 when stage k+1 is empty or is itself advancing in the same cycle (bubble collapsing).
REQ-025 ready_out = !valid(s[0]) || s[0] advancing; the enable chain runs combinationally from ready_in.
REQ-026 Latency: a transaction accepted at edge N with no backpressure SHALL present valid_out in the cycle after edge N+STAGES-1.
REQ-027 Throughput: with ready_in held at 1 the block SHALL accept and deliver one transaction per cycle with no bubbles.
REQ-028 While valid_out=1 && ready_in=0, result, overflow and tag_out SHALL hold stable and no transaction SHALL be dropped or duplicated.
REQ-029 Ordering: outputs SHALL appear in acceptance order.
REQ-030 Full: with all STAGES slots valid and ready_in=0, ready_out SHALL be 0.
REQ-031 Full, with ready_in=1: ready_out SHALL be 1 and a new input is accepted in the same cycle as the output transfer.
REQ-032 occupancy: +1 on an input transfer, -1 on an output transfer, unchanged when both or neither occur.
REQ-033 Behaviour is independent of valid_in/operands when ready_out=0 (held inputs are not sampled).

Reset
REQ-034 Asserting reset (low) SHALL asynchronously clear all stage valid bits, valid_out, occupancy, result, overflow and tag_out to 0.
REQ-035 ready_out SHALL be 1 while reset is deasserted and the block is empty; in-flight transactions at reset assertion are discarded.

Verification
REQ-036 WIDTH=32, STAGES=3: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow 1, valid_out exactly 3 cycles after acceptance.
REQ-037 MUL 0x00010000*0x00010000 -> result 0, overflow 1; MUL -2*3 -> 0xFFFFFFFA, overflow 0; SUB 3-1 tag 5 -> result 2, tag_out 5.
REQ-038 Stream 20 back-to-back transactions with ready_in=1 -> 20 outputs on 20 consecutive cycles, in order, occupancy steady at 3.
REQ-039 ready_in=0 while 5 inputs are offered -> exactly 3 accepted, ready_out=0, occupancy=3, head output stable; then ready_in=1 -> remaining 2 accepted, all 5 delivered in order.
REQ-040 Random valid_in/ready_in toggling, 1000 transactions, STAGES in {1,4,8} -> identical result/tag sequences across configurations against a reference model.
REQ-041 Assert reset with occupancy=2 -> valid_out=0 and occupancy=0 immediately, no stale output after release.
